// File: rtl/serial_adder_subtractor.sv
// Digit-serial two's-complement adder/subtractor: WIDTH-bit operands handled
// DIGIT bits per clock from the LSB up, with start/busy/done handshake and flags.
module serial_adder_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    generate
        if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("serial_adder_subtractor: WIDTH must be >= 2 and an integer multiple of DIGIT");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] z_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    logic [DIGIT-1:0] a_dig_s;
    logic [DIGIT-1:0] b_dig_s;
    logic [DIGIT-1:0] sum_s;
    logic             carry_d;
    logic             msb_cin_s;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] acc_d;

    // One digit of the ripple sum; operands shift down, results fill from the top.
    always_comb begin
        a_dig_s            = a_q[DIGIT-1:0];
        b_dig_s            = b_q[DIGIT-1:0];
        {carry_d, sum_s}   = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {{DIGIT{1'b0}}, carry_q};
        // Sum bit = a ^ b ^ cin, so the carry into the digit MSB falls out directly.
        msb_cin_s          = sum_s[DIGIT-1] ^ a_dig_s[DIGIT-1] ^ b_dig_s[DIGIT-1];
        a_d                = a_q >> DIGIT;
        b_d                = b_q >> DIGIT;
        acc_d              = acc_q >> DIGIT;
        acc_d[WIDTH-1 -: DIGIT] = sum_s;
    end

    // Control FSM, datapath registers and registered result/flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= x;
                        b_q     <= y ^ {WIDTH{control}};
                        carry_q <= control;
                        acc_q   <= {WIDTH{1'b0}};
                        cnt_q   <= {CW{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    acc_q   <= acc_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        z_q     <= acc_d;
                        cout_q  <= carry_d;
                        ovf_q   <= msb_cin_s ^ carry_d;
                        zero_q  <= (acc_d == {WIDTH{1'b0}});
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign z        = z_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule
